// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer sitting upstream of the PC register.
// Computes the next program count, drives the PC load enable, addresses the
// synchronous instruction memory and delivers registered instructions to
// decode. Supports free-running (start), single-step (step) and halt on HLT
// (opcode 0).
//
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   start, step        one-cycle command pulses, honoured only in IDLE
//   program_count      current PC register value
//   new_program_count  program_count + 1 (wraps), combinational
//   pc_enable          PC load enable, combinational
//   instr_addr         instruction memory address (= program_count)
//   instr_data         memory read data, valid one cycle after its address
//   instruction        registered instruction word to decode
//   instr_valid        one-cycle strobe per delivered instruction
//   halted             sticky flag set on HLT, cleared only by reset
//   cycle_count        fetch cycles (RUN/STEP_ISSUE/STEP_WAIT)
//
// Configuration macro: FETCH_CYCLE_COUNT_EN enables the cycle counter;
// when undefined cycle_count is tied to 0.

module fetch_unit #(
    parameter int LENGTH       = 11,
    parameter int INSTR_WIDTH  = 16,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   step,
    input  logic [LENGTH-1:0]      program_count,
    output logic [LENGTH-1:0]      new_program_count,
    output logic                   pc_enable,
    output logic [LENGTH-1:0]      instr_addr,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic                   halted,
    output logic [31:0]            cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP_ISSUE,
        STEP_WAIT,
        HALT
    } state_t;

    state_t state;

    // Set once an address has been issued, so instr_data holds a real word.
    logic data_pending;
    logic is_hlt;

    assign is_hlt            = (instr_data[INSTR_WIDTH-1 -: OPCODE_WIDTH] == '0);
    assign new_program_count = program_count + LENGTH'(1);
    assign instr_addr        = program_count;

    // In RUN the PC is frozen in the same cycle the HLT word shows up, so the
    // final PC points just past the HLT address.
    always_comb begin
        pc_enable = 1'b0;
        case (state)
            RUN:        pc_enable = !(data_pending && is_hlt);
            STEP_ISSUE: pc_enable = 1'b1;
            default:    pc_enable = 1'b0;
        endcase
    end

    // Control FSM with registered instruction/valid/halted outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            data_pending <= 1'b0;
            instruction  <= '0;
            instr_valid  <= 1'b0;
            halted       <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    data_pending <= 1'b0;
                    if (start) begin
                        state <= RUN;
                    end else if (step) begin
                        state <= STEP_ISSUE;
                    end
                end
                RUN: begin
                    data_pending <= 1'b1;
                    if (data_pending) begin
                        if (is_hlt) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            instruction <= instr_data;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                STEP_ISSUE: begin
                    data_pending <= 1'b1;
                    state        <= STEP_WAIT;
                end
                STEP_WAIT: begin
                    data_pending <= 1'b0;
                    if (is_hlt) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        instruction <= instr_data;
                        instr_valid <= 1'b1;
                        state       <= IDLE;
                    end
                end
                HALT: begin
                    data_pending <= 1'b0;
                end
                default: begin
                    data_pending <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    // Counts only active fetch cycles; frozen in IDLE and HALT, wraps at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (state == RUN || state == STEP_ISSUE || state == STEP_WAIT) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Models the PC register
// and a synchronous instruction memory; expected instructions are queued when
// a command is issued and popped whenever instr_valid is seen.

module tb_fetch_unit;

    localparam int LENGTH       = 11;
    localparam int INSTR_WIDTH  = 16;
    localparam int OPCODE_WIDTH = 5;

`ifdef FETCH_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              step  = 1'b0;
    logic [10:0]       pc_reg;
    logic [10:0]       new_program_count;
    logic              pc_enable;
    logic [10:0]       instr_addr;
    logic [15:0]       instr_data;
    logic [15:0]       instruction;
    logic              instr_valid;
    logic              halted;
    logic [31:0]       cycle_count;

    logic              pc_load     = 1'b0;
    logic [10:0]       pc_load_val = '0;
    logic [15:0]       mem [0:2047];
    logic [15:0]       exp_q [$];
    logic [15:0]       exp_word;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .LENGTH(LENGTH),
        .INSTR_WIDTH(INSTR_WIDTH),
        .OPCODE_WIDTH(OPCODE_WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .step(step),
        .program_count(pc_reg),
        .new_program_count(new_program_count),
        .pc_enable(pc_enable),
        .instr_addr(instr_addr),
        .instr_data(instr_data),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .halted(halted),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // PC register model; it is not touched by the fetch unit's reset.
    always @(posedge clk) begin
        if (pc_load) pc_reg <= pc_load_val;
        else if (pc_enable) pc_reg <= pc_reg + 11'd1;
    end

    // Synchronous-read instruction memory.
    always @(posedge clk) begin
        instr_data <= mem[instr_addr];
    end

    task cycle();
        @(posedge clk);
        #1;
    endtask

    task fill_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h8000 | 16'(i);
    endtask

    task preset_pc(input logic [10:0] v);
        pc_load = 1'b1;
        pc_load_val = v;
        cycle();
        pc_load = 1'b0;
    endtask

    task do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        exp_q.delete();
        cycle();
    endtask

    task test_reset();
        #1 reset = 1'b1;
        #1;
        checks++; if (instruction !== 16'h0) begin failures++; $display("[TB] FAIL reset_instruction actual=%h expected=0000", instruction); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%b expected=0", instr_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted actual=%b expected=0", halted); end
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("[TB] FAIL reset_cycle_count actual=%0d expected=0", cycle_count); end
        checks++; if (pc_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_pc_enable actual=%b expected=0", pc_enable); end
        cycle();
        reset = 1'b0;
        cycle();
    endtask

    task test_run_halt();
        int n_valid, first, last;
        do_reset();
        fill_mem();
        mem[0] = 16'h0801; mem[1] = 16'h1002; mem[2] = 16'h1803; mem[3] = 16'h0000;
        preset_pc(11'd0);
        exp_q.push_back(16'h0801); exp_q.push_back(16'h1002); exp_q.push_back(16'h1803);
        start = 1'b1;
        cycle();
        start = 1'b0;
        n_valid = 0; first = 0; last = 0;
        for (int i = 1; i <= 12; i++) begin
            if (instr_valid) begin
                n_valid++;
                if (first == 0) first = i;
                last = i;
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL run_unexpected actual=%h expected=none", instruction); end
                else begin
                    exp_word = exp_q.pop_front();
                    if (instruction !== exp_word) begin failures++; $display("[TB] FAIL run_instr actual=%h expected=%h", instruction, exp_word); end
                end
            end
            cycle();
        end
        checks++; if (first != 3) begin failures++; $display("[TB] FAIL run_latency actual=%0d expected=3", first); end
        checks++; if (n_valid != 3 || last != 5) begin failures++; $display("[TB] FAIL run_consecutive actual=%0d/%0d expected=3/5", n_valid, last); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL run_missing actual=%0d expected=0", exp_q.size()); end
        checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL run_halted actual=%b expected=1", halted); end
        checks++; if (pc_reg !== 11'd4) begin failures++; $display("[TB] FAIL run_final_pc actual=%0d expected=4", pc_reg); end
        checks++; if (cycle_count !== (CNT_EN ? 32'd5 : 32'd0)) begin failures++; $display("[TB] FAIL run_cycle_count actual=%0d expected=%0d", cycle_count, CNT_EN ? 5 : 0); end
    endtask

    task test_step();
        int idx, nv, vat;
        do_reset();
        fill_mem();
        mem[0] = 16'h0801; mem[1] = 16'h1002; mem[2] = 16'h1803; mem[3] = 16'h0000;
        preset_pc(11'd0);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) exp_q.push_back(mem[k]);
            step = 1'b1;
            cycle();
            idx = 1;
            // second step pulse lands in STEP_ISSUE and must be ignored
            if (k == 1) begin cycle(); idx = 2; end
            step = 1'b0;
            nv = 0; vat = 0;
            while (idx <= 5) begin
                if (instr_valid) begin
                    nv++; vat = idx;
                    checks++;
                    if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL step_unexpected actual=%h expected=none", instruction); end
                    else begin
                        exp_word = exp_q.pop_front();
                        if (instruction !== exp_word) begin failures++; $display("[TB] FAIL step_instr actual=%h expected=%h", instruction, exp_word); end
                    end
                end
                cycle();
                idx++;
            end
            if (k < 3) begin
                checks++; if (nv != 1 || vat != 3) begin failures++; $display("[TB] FAIL step_valid count=%0d at=%0d expected=1 at 3", nv, vat); end
                checks++; if (pc_reg !== 11'(k + 1)) begin failures++; $display("[TB] FAIL step_pc actual=%0d expected=%0d", pc_reg, k + 1); end
                checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL step_halted actual=%b expected=0", halted); end
            end else begin
                checks++; if (nv != 0) begin failures++; $display("[TB] FAIL step_hlt_valid actual=%0d expected=0", nv); end
                checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL step_hlt_halted actual=%b expected=1", halted); end
                checks++; if (pc_reg !== 11'd4) begin failures++; $display("[TB] FAIL step_hlt_pc actual=%0d expected=4", pc_reg); end
            end
        end
        checks++; if (cycle_count !== (CNT_EN ? 32'd8 : 32'd0)) begin failures++; $display("[TB] FAIL step_cycle_count actual=%0d expected=%0d", cycle_count, CNT_EN ? 8 : 0); end
    endtask

    task test_start_step_same();
        int n_valid, first, last;
        do_reset();
        fill_mem();
        mem[10] = 16'h0000;
        preset_pc(11'd0);
        for (int i = 0; i < 10; i++) exp_q.push_back(mem[i]);
        start = 1'b1; step = 1'b1;
        cycle();
        start = 1'b0; step = 1'b0;
        n_valid = 0; first = 0; last = 0;
        for (int i = 1; i <= 20; i++) begin
            if (instr_valid) begin
                n_valid++;
                if (first == 0) first = i;
                last = i;
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL both_unexpected actual=%h expected=none", instruction); end
                else begin
                    exp_word = exp_q.pop_front();
                    if (instruction !== exp_word) begin failures++; $display("[TB] FAIL both_instr actual=%h expected=%h", instruction, exp_word); end
                end
            end
            cycle();
        end
        checks++; if (n_valid != 10 || first != 3 || last != 12) begin failures++; $display("[TB] FAIL both_stream n=%0d first=%0d last=%0d expected 10/3/12", n_valid, first, last); end
        checks++; if (halted !== 1'b1 || pc_reg !== 11'd11) begin failures++; $display("[TB] FAIL both_halt halted=%b pc=%0d expected 1/11", halted, pc_reg); end
        checks++; if (cycle_count !== (CNT_EN ? 32'd12 : 32'd0)) begin failures++; $display("[TB] FAIL both_cycle_count actual=%0d expected=%0d", cycle_count, CNT_EN ? 12 : 0); end
    endtask

    task test_wrap();
        int n_valid, wrap_seen;
        do_reset();
        fill_mem();
        mem[2] = 16'h0000;
        preset_pc(11'd2045);
        exp_q.push_back(mem[2045]); exp_q.push_back(mem[2046]); exp_q.push_back(mem[2047]);
        exp_q.push_back(mem[0]); exp_q.push_back(mem[1]);
        start = 1'b1;
        cycle();
        start = 1'b0;
        n_valid = 0; wrap_seen = 0;
        for (int i = 1; i <= 15; i++) begin
            checks++; if (new_program_count !== pc_reg + 11'd1) begin failures++; $display("[TB] FAIL wrap_next_pc actual=%0d expected=%0d", new_program_count, pc_reg + 11'd1); end
            if (pc_reg == 11'h7FF) begin
                wrap_seen++;
                checks++; if (new_program_count !== 11'd0 || instr_addr !== 11'h7FF) begin failures++; $display("[TB] FAIL wrap_edge next=%0d addr=%0d expected 0/2047", new_program_count, instr_addr); end
            end
            if (instr_valid) begin
                n_valid++;
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL wrap_unexpected actual=%h expected=none", instruction); end
                else begin
                    exp_word = exp_q.pop_front();
                    if (instruction !== exp_word) begin failures++; $display("[TB] FAIL wrap_instr actual=%h expected=%h", instruction, exp_word); end
                end
            end
            cycle();
        end
        checks++; if (n_valid != 5 || wrap_seen != 1) begin failures++; $display("[TB] FAIL wrap_count n=%0d seen=%0d expected 5/1", n_valid, wrap_seen); end
        checks++; if (halted !== 1'b1 || pc_reg !== 11'd3) begin failures++; $display("[TB] FAIL wrap_halt halted=%b pc=%0d expected 1/3", halted, pc_reg); end
    endtask

    task test_reset_mid_run();
        int n_valid, first;
        do_reset();
        fill_mem();
        mem[8] = 16'h0000;
        preset_pc(11'd0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 20 && pc_reg != 11'd5; i++) cycle();
        checks++; if (pc_reg !== 11'd5) begin failures++; $display("[TB] FAIL midrst_reach_pc5 actual=%0d expected=5", pc_reg); end
        reset = 1'b1;
        #1;
        checks++; if (instruction !== 16'h0 || instr_valid !== 1'b0 || halted !== 1'b0) begin failures++; $display("[TB] FAIL midrst_outputs instr=%h valid=%b halted=%b expected 0/0/0", instruction, instr_valid, halted); end
        checks++; if (pc_enable !== 1'b0 || cycle_count !== 32'd0) begin failures++; $display("[TB] FAIL midrst_pc_en pc_enable=%b count=%0d expected 0/0", pc_enable, cycle_count); end
        cycle();
        reset = 1'b0;
        exp_q.delete();
        checks++; if (pc_reg !== 11'd5) begin failures++; $display("[TB] FAIL midrst_pc_hold actual=%0d expected=5", pc_reg); end
        exp_q.push_back(mem[5]); exp_q.push_back(mem[6]); exp_q.push_back(mem[7]);
        start = 1'b1;
        cycle();
        start = 1'b0;
        n_valid = 0; first = 0;
        for (int i = 1; i <= 12; i++) begin
            if (instr_valid) begin
                n_valid++;
                if (first == 0) first = i;
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL midrst_unexpected actual=%h expected=none", instruction); end
                else begin
                    exp_word = exp_q.pop_front();
                    if (instruction !== exp_word) begin failures++; $display("[TB] FAIL midrst_instr actual=%h expected=%h", instruction, exp_word); end
                end
            end
            cycle();
        end
        checks++; if (n_valid != 3 || first != 3) begin failures++; $display("[TB] FAIL midrst_stream n=%0d first=%0d expected 3/3", n_valid, first); end
        checks++; if (halted !== 1'b1 || pc_reg !== 11'd9) begin failures++; $display("[TB] FAIL midrst_halt halted=%b pc=%0d expected 1/9", halted, pc_reg); end
    endtask

    task test_halt_ignore();
        logic [10:0] pc_before;
        pc_before = pc_reg;
        for (int i = 0; i < 6; i++) begin
            start = (i == 1);
            step  = (i == 3);
            cycle();
            checks++; if (pc_enable !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_ignore pc_enable=%b valid=%b halted=%b expected 0/0/1", pc_enable, instr_valid, halted); end
        end
        start = 1'b0;
        step  = 1'b0;
        checks++; if (pc_reg !== pc_before) begin failures++; $display("[TB] FAIL halt_pc actual=%0d expected=%0d", pc_reg, pc_before); end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_run_halt();
        test_step();
        test_start_step_same();
        test_wrap();
        test_reset_mid_run();
        test_halt_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
